// File: rtl/ndp_pkg.sv
// Shared NDP definitions: core geometry defaults, drain FSM state and size helpers.
package ndp_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ARR_WIDTH  = 4;
    localparam int DEF_ARR_HEIGHT = 4;
    localparam int DEF_SYS_WIDTH  = 64;
    localparam int DEF_SYS_HEIGHT = 1;
    localparam int DEF_OUT_WIDTH  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    function automatic int calc_total(input int width, input int arr_w, input int arr_h,
                                      input int sys_w, input int sys_h);
        return arr_w * sys_w * arr_h * sys_h * width;
    endfunction

    function automatic int calc_num_words(input int total, input int out_width);
        return total / out_width;
    endfunction

    function automatic int calc_epw(input int out_width, input int width);
        return out_width / width;
    endfunction

endpackage

// File: rtl/ndp_word_select.sv
// Combinational slice of the capture buffer by word index; lowest element in the low bits.
// Optional per-element ReLU (MSB set -> zero) when NDP_DRAIN_RELU_EN is defined.
module ndp_word_select #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TOTAL     = 16384,
    parameter int IDX_W     = 9
) (
    input  logic [TOTAL-1:0]     cap_buf,
    input  logic [IDX_W-1:0]     word_idx,
    output logic [OUT_WIDTH-1:0] word
);

    logic [OUT_WIDTH-1:0] raw;

    assign raw = cap_buf[int'(word_idx) * OUT_WIDTH +: OUT_WIDTH];

`ifdef NDP_DRAIN_RELU_EN
    localparam int EPW = ndp_pkg::calc_epw(OUT_WIDTH, WIDTH);

    // Sign bit is the MSB for both FP16 and two's complement, so one test covers both.
    always_comb begin
        word = raw;
        for (int e = 0; e < EPW; e++) begin
            if (raw[e*WIDTH + WIDTH - 1]) begin
                word[e*WIDTH +: WIDTH] = '0;
            end
        end
    end
`else
    assign word = raw;
`endif

endmodule

// File: rtl/ndp_result_drain.sv
// Captures out_c on a calc_done_flag rise and streams it as OUT_WIDTH words, 1 word/cycle,
// first word one cycle after the rise; holds word while out_ready low. ReLU: NDP_DRAIN_RELU_EN.
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ARR_WIDTH  = DEF_ARR_WIDTH,
    parameter int ARR_HEIGHT = DEF_ARR_HEIGHT,
    parameter int SYS_WIDTH  = DEF_SYS_WIDTH,
    parameter int SYS_HEIGHT = DEF_SYS_HEIGHT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    localparam int TOTAL     = calc_total(WIDTH, ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 calc_done_flag,
    input  logic [TOTAL-1:0]     out_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 drain_done,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int NUM_WORDS = calc_num_words(TOTAL, OUT_WIDTH);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    drain_state_t         state, state_nxt;
    logic [IDX_W-1:0]     word_idx, word_idx_nxt;
    logic [TOTAL-1:0]     cap_buf;
    logic                 done_q;
    logic                 rise;
    logic                 load;
    logic                 drain_done_nxt;
    logic                 overrun_set;
    logic [OUT_WIDTH-1:0] sel_word;

    assign rise        = calc_done_flag & ~done_q;
    assign overrun_set = rise && (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            done_q     <= 1'b1;
            drain_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_idx   <= word_idx_nxt;
            done_q     <= calc_done_flag;
            drain_done <= drain_done_nxt;
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Contents are irrelevant outside DRAIN, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            cap_buf <= out_c;
        end
    end

    always_comb begin
        state_nxt      = state;
        word_idx_nxt   = word_idx;
        load           = 1'b0;
        drain_done_nxt = 1'b0;
        out_valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    load         = 1'b1;
                    word_idx_nxt = '0;
                    state_nxt    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (word_idx == LAST_IDX) begin
                        state_nxt      = ST_IDLE;
                        drain_done_nxt = 1'b1;
                    end else begin
                        word_idx_nxt = word_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    ndp_word_select #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .TOTAL     (TOTAL),
        .IDX_W     (IDX_W)
    ) u_word_select (
        .cap_buf   (cap_buf),
        .word_idx  (word_idx),
        .word      (sel_word)
    );

    assign busy     = (state == ST_DRAIN);
    assign out_data = out_valid ? sel_word : '0;
    assign out_last = out_valid && (word_idx == LAST_IDX);

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed bench for ndp_result_drain at default geometry (512 words of 32 bits).
module tb_ndp_result_drain;

    localparam int TOTAL = 16384;
    localparam int NW    = 512;
    localparam int OW    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             calc_done_flag;
    logic [TOTAL-1:0] out_c;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    logic             drain_done;
    logic             overrun;
    logic             overrun_clr;

    logic [TOTAL-1:0] model_vec;
    int               n_checks = 0;
    int               n_errors = 0;

    ndp_result_drain #(
        .WIDTH      (16),
        .ARR_WIDTH  (4),
        .ARR_HEIGHT (4),
        .SYS_WIDTH  (64),
        .SYS_HEIGHT (1),
        .OUT_WIDTH  (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .calc_done_flag (calc_done_flag),
        .out_c          (out_c),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .drain_done     (drain_done),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        w = model_vec[k*OW +: OW];
`ifdef NDP_DRAIN_RELU_EN
        for (int e = 0; e < 2; e++) begin
            if (w[e*16 + 15]) w[e*16 +: 16] = 16'h0000;
        end
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < TOTAL/16; i++) out_c[i*16 +: 16] = 16'(i);
    endtask

    // Low for one cycle, then high: the rise is sampled at the second edge.
    // Returns in the first cycle of the drain.
    task automatic start_drain();
        calc_done_flag = 1'b0;
        tick();
        model_vec      = out_c;
        calc_done_flag = 1'b1;
        tick();
        calc_done_flag = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;

        reset = 1'b1; calc_done_flag = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
        out_c = '0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", out_data, 32'h0);
        reset = 1'b0;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Full drain with out_ready held high
        fill_ramp();
        out_ready = 1'b1;
        start_drain();
        check("t1_busy", 32'(busy), 32'd1);
        for (int w = 0; w < NW; w++) begin
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data", out_data, exp_word(w));
            check("t1_last", 32'(out_last), (w == NW-1) ? 32'd1 : 32'd0);
            if (w == 0)    check("t1_word0", out_data, 32'h00010000);
            if (w == NW-1) check("t1_word511", out_data, 32'h03FF03FE);
            if (w == 5)    check("t1_no_early_done", 32'(drain_done), 32'd0);
            tick();
        end
        check("t1_done_pulse", 32'(drain_done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_valid_end", 32'(out_valid), 32'd0);
        tick();
        check("t1_done_one_cycle", 32'(drain_done), 32'd0);

        // Random backpressure: order and stall stability
        start_drain();
        k = 0; cyc = 0;
        while (k < NW && cyc < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_data", out_data, exp_word(k));
            if (out_ready) k++;
            tick();
            cyc++;
        end
        check("t2_word_count", 32'(k), 32'(NW));
        check("t2_done", 32'(drain_done), 32'd1);
        out_ready = 1'b1;

        // Overrun at word 100, clear mid-drain, then rise together with clear on last handshake
        start_drain();
        for (int w = 0; w < NW; w++) begin
            check("t3_data", out_data, exp_word(w));
            if (w == 100) begin
                out_c = ~out_c;
                calc_done_flag = 1'b1;
            end
            if (w == 101) begin
                calc_done_flag = 1'b0;
                check("t3_overrun_set", 32'(overrun), 32'd1);
                check("t3_still_busy", 32'(busy), 32'd1);
            end
            if (w == 200) overrun_clr = 1'b1;
            if (w == 201) begin
                overrun_clr = 1'b0;
                check("t3_overrun_clr", 32'(overrun), 32'd0);
            end
            if (w == NW-1) begin
                calc_done_flag = 1'b1;
                overrun_clr = 1'b1;
            end
            tick();
        end
        overrun_clr = 1'b0;
        check("t3_set_wins", 32'(overrun), 32'd1);
        check("t3_done", 32'(drain_done), 32'd1);
        check("t3_no_recapture", 32'(out_valid), 32'd0);
        calc_done_flag = 1'b0;
        tick();
        check("t3_idle", 32'(busy), 32'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3_overrun_cleared", 32'(overrun), 32'd0);

        // Reset at word 300 aborts the drain
        fill_ramp();
        start_drain();
        for (int w = 0; w < 300; w++) begin
            if (w == 50) calc_done_flag = 1'b1;
            if (w == 51) calc_done_flag = 1'b0;
            tick();
        end
        check("t4_word300", out_data, exp_word(300));
        check("t4_overrun_before", 32'(overrun), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_overrun", 32'(overrun), 32'd0);
        check("t4_data", out_data, 32'h0);
        start_drain();
        check("t4_restart_valid", 32'(out_valid), 32'd1);
        check("t4_restart_word0", out_data, exp_word(0));
        check("t4_restart_last", 32'(out_last), 32'd0);
        reset = 1'b1;
        tick();

        // Flag held high through reset release is not a capture
        calc_done_flag = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("t5_no_capture_valid", 32'(out_valid), 32'd0);
        check("t5_no_capture_busy", 32'(busy), 32'd0);
        start_drain();
        check("t5_capture_valid", 32'(out_valid), 32'd1);
        check("t5_capture_word0", out_data, exp_word(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Negative element handling in word 0
        out_c = '0;
        out_c[15:0]  = 16'h8001;
        out_c[31:16] = 16'h3C00;
        start_drain();
        check("t6_valid", 32'(out_valid), 32'd1);
`ifdef NDP_DRAIN_RELU_EN
        check("t6_word0", out_data, 32'h3C000000);
`else
        check("t6_word0", out_data, 32'h3C008001);
`endif
        tick();
        check("t6_word1", out_data, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
